// File: rtl/wb_arb_pkg.sv
// Shared types and Wishbone width defaults for the guarded two-master arbiter.
package wb_arb_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 32;
  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_ABORT
  } arb_state_e;

  typedef enum logic {
    OWN_M0,
    OWN_M1
  } arb_owner_e;

  // One-hot grant vector for an owner: bit0 = m0, bit1 = m1.
  function automatic logic [1:0] owner_onehot(input arb_owner_e owner);
    return (owner == OWN_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Counts consecutive stalled strobe cycles and flags the cycle on which the
// bus tenure must be aborted.
module wb_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic stall,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  // Next count: clear wins, otherwise count stalls up to the threshold and hold.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clear) begin
      wd_cnt_d = '0;
    end else if (stall && (wd_cnt_q != LAST)) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Fires only while the stall still holds, so an ack on this cycle wins.
  assign expire = stall && !clear && (wd_cnt_q == LAST);

endmodule

// File: rtl/wb_arbiter_guarded.sv
// Two-master Wishbone classic arbiter: m1 (data) has fixed priority, a
// starvation guard forces an m0 (fetch) grant, and a watchdog aborts
// tenures whose slave never responds.
module wb_arbiter_guarded
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q;
  arb_owner_e          owner_q;
  logic [STARVE_W-1:0] starve_cnt_q;
  logic [1:0]          grant_q;
  logic                timeout_q;

  logic busy, abort, own_m0, own_m1, own_cyc, own_stb;
  logic pick_m1, stall, wd_clear, wd_expire;

  assign busy    = (state_q == ARB_BUSY);
  assign abort   = (state_q == ARB_ABORT);
  assign own_m0  = (owner_q == OWN_M0);
  assign own_m1  = (owner_q == OWN_M1);
  assign own_cyc = own_m1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own_m1 ? m1_stb_i : m0_stb_i;

  // m1 wins unless m0 is waiting and has already been passed over too often.
  assign pick_m1 = m1_cyc_i && !(m0_cyc_i && (starve_cnt_q == STARVE_MAX));

  assign stall    = busy && own_cyc && own_stb && !s_ack_i && !s_err_i;
  assign wd_clear = !busy || s_ack_i || s_err_i;

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clear (wd_clear),
    .stall (stall),
    .expire(wd_expire)
  );

  // Arbitration FSM with starvation counter and registered grant/timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_M0;
      starve_cnt_q <= '0;
      grant_q      <= 2'b00;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            state_q <= ARB_BUSY;
            if (pick_m1) begin
              owner_q <= OWN_M1;
              grant_q <= owner_onehot(OWN_M1);
              if (m0_cyc_i && (starve_cnt_q != STARVE_MAX)) begin
                starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
              end
            end else begin
              owner_q      <= OWN_M0;
              grant_q      <= owner_onehot(OWN_M0);
              starve_cnt_q <= '0;
            end
          end
        end
        ARB_BUSY: begin
          // Release has priority over a simultaneous watchdog expiry.
          if (!own_cyc) begin
            state_q <= ARB_IDLE;
            grant_q <= 2'b00;
          end else if (wd_expire) begin
            state_q   <= ARB_ABORT;
            timeout_q <= 1'b1;
          end
        end
        ARB_ABORT: begin
          state_q <= ARB_IDLE;
          grant_q <= 2'b00;
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // Slave-side mux: mirror the owner during BUSY, quiet otherwise.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (busy) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_cyc && own_stb;
      s_we_o  = own_m1 ? m1_we_i  : m0_we_i;
      s_adr_o = own_m1 ? m1_adr_i : m0_adr_i;
      s_dat_o = own_m1 ? m1_dat_i : m0_dat_i;
      s_sel_o = own_m1 ? m1_sel_i : m0_sel_i;
    end
  end

  // Master-side return path: slave response goes only to the owner.
  always_comb begin
    m0_ack_o = busy && own_m0 && s_ack_i;
    m1_ack_o = busy && own_m1 && s_ack_i;
    m0_err_o = own_m0 && ((busy && s_err_i) || abort);
    m1_err_o = own_m1 && ((busy && s_err_i) || abort);
    m0_dat_o = (busy && own_m0) ? s_dat_i : '0;
    m1_dat_o = (busy && own_m1) ? s_dat_i : '0;
  end

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arbiter_guarded.sv
// Self-checking bench for wb_arbiter_guarded (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_wb_arbiter_guarded;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned TMO   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic [SW-1:0] s_sel;
  logic          s_ack, s_err;
  logic [1:0]    grant;
  logic          timeout;

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [31:0]   exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter_guarded #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SELECT_WIDTH  (SW),
    .STARVE_LIMIT  (LIMIT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_we_i  (m0_we),
    .m0_adr_i (m0_adr),
    .m0_dat_i (m0_wdat),
    .m0_sel_i (m0_sel),
    .m0_dat_o (m0_rdat),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_we_i  (m1_we),
    .m1_adr_i (m1_adr),
    .m1_dat_i (m1_wdat),
    .m1_sel_i (m1_sel),
    .m1_dat_o (m1_rdat),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_wdat),
    .s_sel_o  (s_sel),
    .s_dat_i  (s_rdat),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .grant_o  (grant),
    .timeout_o(timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 2ns after the rising edge; outputs are sampled after settle().
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = '0;
    s_rdat = '0; s_ack = 0; s_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    logic       ack0_prev, ack1_prev;
    logic [1:0] prev_grant;
    int         elapsed, beats;
    logic       found;

    // Reset values.
    idle_inputs();
    rst_n = 1'b0;
    #3;
    check_eq("rst_s_cyc", {31'd0, s_cyc}, 0);
    check_eq("rst_grant", {30'd0, grant}, 0);
    check_eq("rst_timeout", {31'd0, timeout}, 0);
    check_eq("rst_m0_dat", m0_rdat, 0);

    // Lone m0 read acked two cycles after the strobe.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100; m0_sel = '1;
    exp_q.push_back(32'hDEAD_BEEF);
    next_cycle(); settle();
    check_eq("m0_grant", {30'd0, grant}, 32'h1);
    check_eq("m0_s_adr", s_adr, 32'h0000_0100);
    check_eq("m0_ack_wait1", {31'd0, m0_ack}, 0);
    next_cycle(); settle();
    check_eq("m0_ack_wait2", {31'd0, m0_ack}, 0);
    next_cycle(); s_ack = 1; s_rdat = 32'hDEAD_BEEF; settle();
    check_eq("m0_ack", {31'd0, m0_ack}, 1);
    check_eq("m0_rdat", m0_rdat, exp_q.pop_front());
    check_eq("m1_rdat_quiet", m1_rdat, 0);
    check_eq("m1_ack_quiet", {31'd0, m1_ack}, 0);
    next_cycle(); s_ack = 0; s_rdat = '0; m0_cyc = 0; m0_stb = 0; settle();
    next_cycle(); settle();
    check_eq("m0_release", {30'd0, grant}, 0);

    // Both masters request continuously; each tenure is acked on its first strobe.
    do_reset();
    exp_q = {32'h2, 32'h2, 32'h2, 32'h2, 32'h1, 32'h2};
    ack0_prev = 0; ack1_prev = 0; prev_grant = 2'b00;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      m0_cyc = !ack0_prev; m0_stb = m0_cyc;
      m1_cyc = !ack1_prev; m1_stb = m1_cyc;
      settle();
      s_ack = s_cyc & s_stb;
      settle();
      if (grant != 2'b00 && prev_grant == 2'b00) check_eq("starve_order", {30'd0, grant}, exp_q.pop_front());
      prev_grant = grant; ack0_prev = m0_ack; ack1_prev = m1_ack;
      next_cycle();
    end
    check_eq("starve_order_left", exp_q.size(), 0);

    // Slave never acks: abort exactly TMO cycles after the first stalled strobe.
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    next_cycle(); settle();
    check_eq("tmo_grant", {30'd0, grant}, 32'h1);
    found = 0; elapsed = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      next_cycle(); settle();
      if (timeout) begin found = 1; elapsed = i; end
    end
    check_eq("tmo_latency", elapsed, TMO);
    check_eq("tmo_m0_err", {31'd0, m0_err}, 1);
    check_eq("tmo_m1_err", {31'd0, m1_err}, 0);
    check_eq("tmo_s_cyc", {31'd0, s_cyc}, 0);
    next_cycle(); settle();
    check_eq("tmo_pulse_end", {31'd0, timeout}, 0);
    check_eq("tmo_err_end", {31'd0, m0_err}, 0);
    check_eq("tmo_idle", {30'd0, grant}, 0);
    next_cycle(); settle();
    check_eq("tmo_regrant", {30'd0, grant}, 32'h1);
    check_eq("tmo_regrant_cyc", {31'd0, s_cyc}, 1);
    m0_cyc = 0; m0_stb = 0;

    // Ack lands on the threshold cycle: normal completion, no abort.
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_wdat = 32'h1234_5678;
    next_cycle(); settle();
    check_eq("thr_s_dat", s_wdat, 32'h1234_5678);
    repeat (TMO - 2) next_cycle();
    next_cycle(); s_ack = 1; settle();
    check_eq("thr_ack", {31'd0, m1_ack}, 1);
    check_eq("thr_err", {31'd0, m1_err}, 0);
    next_cycle(); s_ack = 0; m1_cyc = 0; m1_stb = 0; settle();
    check_eq("thr_no_timeout", {31'd0, timeout}, 0);
    check_eq("thr_no_err", {31'd0, m1_err}, 0);
    check_eq("thr_grant_hold", {30'd0, grant}, 32'h2);
    next_cycle(); settle();
    check_eq("thr_idle", {30'd0, grant}, 0);
    check_eq("thr_no_timeout2", {31'd0, timeout}, 0);

    // m1 locks the bus for three beats while m0 waits.
    do_reset();
    exp_q = {32'h2, 32'h2, 32'h2, 32'h2, 32'h0, 32'h1};
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; beats = 0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (beats == 3) begin m1_cyc = 0; m1_stb = 0; end
      settle();
      s_ack = s_cyc & s_stb & grant[1];
      settle();
      check_eq("lock_grant", {30'd0, grant}, exp_q.pop_front());
      if (i < 3) check_eq("lock_m0_ack", {31'd0, m0_ack}, 0);
      if (m1_ack) beats++;
    end
    s_ack = 0; m0_cyc = 0; m0_stb = 0;

    // Asynchronous reset in the middle of a tenure.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0044;
    next_cycle(); s_ack = 1; s_rdat = 32'hCAFE_0001; settle();
    check_eq("arst_pre_dat", m0_rdat, 32'hCAFE_0001);
    #1; rst_n = 1'b0; #1;
    check_eq("arst_s_cyc", {31'd0, s_cyc}, 0);
    check_eq("arst_s_adr", s_adr, 0);
    check_eq("arst_grant", {30'd0, grant}, 0);
    check_eq("arst_m0_ack", {31'd0, m0_ack}, 0);
    check_eq("arst_m0_dat", m0_rdat, 0);
    #1; rst_n = 1'b1; s_ack = 0; s_rdat = '0;
    settle();
    check_eq("arst_still_idle", {30'd0, grant}, 0);
    next_cycle(); settle();
    check_eq("arst_regrant", {30'd0, grant}, 32'h1);
    check_eq("arst_regrant_cyc", {31'd0, s_cyc}, 1);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_guarded.md
# wb_arbiter_guarded

Two-master Wishbone (classic) arbiter that shares a single slave port between the instruction-fetch master (m0) and the data-access master (m1) of the CPU. Data accesses win by fixed priority, and a starvation guard forces a fetch grant after a bounded run of data grants. A bus watchdog aborts any transaction whose slave never acknowledges, returning `err` to the owning master. The block sits between the CPU masters and the address-decoding mux in the top level.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `SELECT_WIDTH`, DATA_WIDTH/8, byte-select width
- `STARVE_LIMIT`, 4, consecutive m1 grants allowed while m0 waits (>=1)
- `TIMEOUT_CYCLES`, 255, un-acked strobe cycles before abort (>=2)

Ports:
- `clk_i` in 1: system clock; single clock domain
- `rst_ni` in 1: reset, asynchronous, active-low
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: fetch master control
- `m0_adr_i` in ADDR_WIDTH, `m0_dat_i` in DATA_WIDTH, `m0_sel_i` in SELECT_WIDTH
- `m0_dat_o` out DATA_WIDTH; `m0_ack_o`, `m0_err_o` out 1
- `m1_*`: same set as m0, for the data master
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1; `s_adr_o` out ADDR_WIDTH; `s_dat_o` out DATA_WIDTH; `s_sel_o` out SELECT_WIDTH
- `s_dat_i` in DATA_WIDTH; `s_ack_i`, `s_err_i` in 1
- `grant_o` out 2: one-hot current owner (bit0=m0, bit1=m1), 0 when idle
- `timeout_o` out 1: one-cycle pulse on abort

## Operation
- States: IDLE, BUSY, ABORT. Owner register holds m0/m1.
- IDLE: if any `mX_cyc_i` is high, register the winner, go BUSY. Winner is m1 if requesting, unless `starve_cnt == STARVE_LIMIT` and m0 is requesting, in which case m0 wins.
- `starve_cnt`: increments on each m1 grant made while m0 `cyc` is high. Clears on any m0 grant. Saturates at STARVE_LIMIT.
- BUSY: slave outputs mirror the owner's inputs. `s_ack_i`, `s_err_i` and `s_dat_i` route combinationally to the owner only. The non-owner sees ack=err=0 and dat=0.
- The grant is held while the owner's `cyc` stays high, so multi-beat cycles stay locked. When the owner drops `cyc`, go to IDLE.
- Watchdog: `wd_cnt` increments each BUSY cycle with `s_stb_o & ~s_ack_i & ~s_err_i`. It clears on ack/err or on leaving BUSY. When `wd_cnt == TIMEOUT_CYCLES-1` and the condition still holds, go to ABORT.
- ABORT (1 cycle): `s_cyc_o`/`s_stb_o` are 0, the owner's `err_o` is 1, and `timeout_o` is 1. Then go to IDLE.
- Simultaneous events:
  - Slave ack on the threshold cycle: the ack wins and there is no abort.
  - Owner drops `cyc` on the threshold cycle: release wins and there is no err.
  - Both masters request in IDLE: priority rule above applies.
- Reset, including mid-transaction: all outputs go to 0 immediately, the state goes to IDLE, and both counters clear. A master that still holds `cyc` after reset is re-arbitrated as a new request.

## Timing
- Reset values: all `s_*` outputs, `mX_ack_o`, `mX_err_o`, `mX_dat_o`, `grant_o` and `timeout_o` are 0.
- Arbitration latency: 1 cycle. A request sampled in IDLE at edge N gives `s_cyc_o` high during cycle N+1.
- Ack/err/data path: 0 cycles (combinational slave to owner).
- Release: owner `cyc` low at edge N gives IDLE in cycle N+1. There is at least one idle bus cycle between tenures.
- Abort: the err pulse occurs exactly TIMEOUT_CYCLES cycles after the first un-acked strobe cycle.
- Widths: `wd_cnt` is $clog2(TIMEOUT_CYCLES+1) bits; `starve_cnt` is $clog2(STARVE_LIMIT+1) bits. Neither counter wraps.

## Structure
- Package `wb_arb_pkg`:
  - `arb_state_e` {ARB_IDLE, ARB_BUSY, ARB_ABORT}
  - `arb_owner_e` {OWN_M0, OWN_M1}
  - Shared Wishbone width defaults
- Sub-module `wb_bus_watchdog`:
  - Inputs: `clk_i`, `rst_ni`, `clear`, `stall`
  - Output: `expire`
  - Parameter: TIMEOUT_CYCLES
- Arbitration FSM and routing muxes live in the top module.

## Test plan
- Lone m0 read, slave acks 2 cycles after strobe: `grant_o`=01 from cycle 1, `m0_ack_o` mirrors `s_ack_i`, and `m0_dat_o`=0xDEADBEEF while m1 sees 0.
- m0 and m1 requesting continuously, each tenure acked in 1 cycle, STARVE_LIMIT=4: grant order is m1,m1,m1,m1,m0,m1…
- Slave never acks, TIMEOUT_CYCLES=8: `timeout_o` pulses once 8 cycles after the strobe, the owner gets `err_o`=1 for 1 cycle, `s_cyc_o` drops, then the next request is granted.
- `s_ack_i` asserted on the exact threshold cycle: no `err_o`, no `timeout_o`, normal completion.
- m1 holds `cyc` for a 3-beat locked cycle while m0 requests: m0 is not granted until m1 drops `cyc`, plus 1 idle cycle.
- `rst_ni` pulsed low mid-BUSY: all outputs are 0 asynchronously, and after release the first request takes the 1-cycle arbitration path.
